instr_fetch: RTL and testbench
==============================

# instr_fetch

Program-counter and fetch-sequencing stage directly upstream of the byte-addressed, little-endian instruction memory in the 32-bit single-cycle processor. Drives the word address into the instruction memory, captures the returned 32-bit instruction into an output register, and hands it to decode over a valid/ready handshake. Handles sequential advance, jump/branch redirect with flush, memory-bound and alignment checks, and halt.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `IMEM_BYTES`, 36: instruction memory size in bytes; must be a multiple of 4.
- `HALT_CODE`, 32'hFFFF_FFFF: instruction word that stops fetching.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `Addr`  out  32  byte address to instruction memory; combinational copy of the PC register.
- `InstrCode`  in  32  instruction returned by memory, valid in the same cycle as `Addr`.
- `jump`  in  1  redirect request, highest priority.
- `jump_target`  in  32  jump destination byte address.
- `branch_taken`  in  1  redirect request, lower priority than `jump`.
- `branch_target`  in  32  branch destination byte address.
- `instr_out`  out  32  registered instruction to decode.
- `pc_out`  out  32  byte address of `instr_out`.
- `valid_out`  out  1  `instr_out`/`pc_out` hold a live instruction.
- `ready_in`  in  1  decode accepts when `valid_out & ready_in`.
- `halted`  out  1  fetch has stopped; sticky until reset.
- `err`  out  1  halt caused by a misaligned or out-of-range PC; sticky.

## Operation
- FSM states: `BOOT`, `RUN`, `HALT`.
- Reset (`reset`=0 at a rising edge): state=`BOOT`, pc=`RESET_PC`, `instr_out`=0, `pc_out`=0, `valid_out`=0, `halted`=0, `err`=0. Reset overrides everything, including mid-handshake.
- `BOOT`: one cycle that lets instruction memory finish its load. No capture. Next state is `RUN`.
- `RUN`, output register is free (`!valid_out | ready_in`), and no redirect:
  - Capture `InstrCode` into `instr_out` and pc into `pc_out`; set `valid_out`=1.
  - pc <= pc+4, 32-bit with modulo-2^32 wrap.
- `RUN`, output register is occupied (`valid_out & !ready_in`): pc, output register and state all hold.
- Redirect (`jump` or `branch_taken` while in `RUN`):
  - Acts regardless of backpressure.
  - pc <= `jump_target` if `jump`, otherwise `branch_target`.
  - `valid_out` <= 0, which flushes the wrong-path instruction. No capture that cycle.
- Redirect target with `[1:0]`≠0: go to `HALT` with `err`=1; pc is not updated.
- Range check before capture in `RUN`: if pc > `IMEM_BYTES`-4, go to `HALT` with `err`=1 and do not capture.
- Halt code: when the captured `InstrCode` equals `HALT_CODE`:
  - It is delivered as a normal instruction (`valid_out`=1).
  - State goes to `HALT`; pc does not advance.
- `HALT`:
  - `halted`=1 from the next cycle.
  - The output register still completes its pending handshake; no new captures.
  - Redirects are ignored. Exit only through reset.
- Priority, highest first: reset > misaligned redirect > `jump` > `branch_taken` > range check > sequential.

## Timing
- Cycle R = first edge with `reset`=1. R is the `BOOT` edge.
- At edge R+1, the first capture: `valid_out`=1, `pc_out`=`RESET_PC`.
- Fetch-to-output latency is 1 cycle. Throughput is 1 instruction per cycle while `ready_in`=1.
- Redirect sampled at edge N: `valid_out`=0 after N; first target instruction is valid after edge N+1. This is a 1-bubble penalty.
- `Addr` changes only after clock edges; it never depends combinationally on `jump`, `branch_taken` or `ready_in`.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (`BOOT`, `RUN`, `HALT`).
  - Localparam `PC_STEP`=4.
  - Default `HALT_CODE`.
- One natural sub-module, `next_pc_sel`: combinational priority mux plus alignment check. Outputs are next pc, redirect flag and misalign flag.
- Everything else (FSM, PC register, output register) lives in `instr_fetch`.

## Test plan
- Sequential fetch: memory words 0x11, 0x22, 0x33 at bytes 0/4/8, `ready_in`=1 → `pc_out` 0,4,8 on consecutive cycles starting at edge R+1.
- Backpressure: `ready_in`=0 for 3 cycles at `pc_out`=4 → `instr_out`, `pc_out` and `Addr`=8 all hold. Release → next `pc_out`=8, with no skip or duplicate.
- Redirect priority: `jump`=1 to 0x10 and `branch_taken`=1 to 0x08 in the same cycle → one bubble (`valid_out`=0), then `pc_out`=0x10.
- Misaligned branch to 0x06 → `halted`=1 and `err`=1 next cycle; no further `valid_out`.
- Halt code at byte 12 → instruction 0xFFFFFFFF delivered with `pc_out`=12, then `halted`=1, `err`=0. Separately, running past byte 32 with `IMEM_BYTES`=36 → `halted`=1, `err`=1, with no capture at pc=36.
- Reset mid-run: drive `reset`=0 while `valid_out`=1 and `ready_in`=0 → next edge shows all outputs at reset values; sequence restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;

    localparam logic [31:0] PC_STEP           = 32'd4;
    localparam logic [31:0] DEFAULT_HALT_CODE = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_slot_t;
endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: jump over branch over sequential, plus target alignment check.
// Latency: combinational.
// Backpressure: none; the caller decides whether the selected pc is applied.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        misalign
);
    always_comb begin
        redirect = jump | branch_taken;
        if (jump)
            next_pc = jump_target;
        else if (branch_taken)
            next_pc = branch_target;
        else
            next_pc = pc + PC_STEP;
        misalign = redirect && (next_pc[1:0] != 2'b00);
    end
endmodule

// File: rtl/instr_fetch.sv
// PC register and fetch sequencer feeding decode through a one-entry output register.
// Latency: one cycle from Addr to instr_out/pc_out; redirects cost one bubble.
// Backpressure: valid_out & !ready_in freezes pc and the output register; redirects still act.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 36,
    parameter logic [31:0] HALT_CODE  = DEFAULT_HALT_CODE
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Addr,
    input  logic [31:0] InstrCode,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        halted,
    output logic        err
);
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    fetch_state_t state;
    fetch_slot_t  out_q;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         redirect;
    logic         misalign;
    logic         out_vld;
    logic         halted_q;
    logic         err_q;
    logic         out_free;

    next_pc_sel u_next_pc_sel (
        .pc            (pc),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .misalign      (misalign)
    );

    assign out_free  = !out_vld || ready_in;
    assign Addr      = pc;
    assign instr_out = out_q.instr;
    assign pc_out    = out_q.pc;
    assign valid_out = out_vld;
    assign halted    = halted_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            out_q    <= '0;
            out_vld  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (misalign) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                        err_q    <= 1'b1;
                        out_vld  <= 1'b0;
                    end else if (redirect) begin
                        pc      <= next_pc;
                        out_vld <= 1'b0;
                    end else if (out_free) begin
                        // Out-of-range pc stops fetch before memory is trusted.
                        if (pc > LAST_PC) begin
                            state    <= HALT;
                            halted_q <= 1'b1;
                            err_q    <= 1'b1;
                            out_vld  <= 1'b0;
                        end else begin
                            out_q   <= '{instr: InstrCode, pc: pc};
                            out_vld <= 1'b1;
                            if (InstrCode == HALT_CODE) begin
                                state    <= HALT;
                                halted_q <= 1'b1;
                            end else begin
                                pc <= next_pc;
                            end
                        end
                    end
                end
                HALT: begin
                    if (out_vld && ready_in)
                        out_vld <= 1'b0;
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Addr, InstrCode, jump_target, branch_target, instr_out, pc_out;
    logic        jump, branch_taken, valid_out, ready_in, halted, err;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] imem [0:15];

    instr_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (36),
        .HALT_CODE  (32'hFFFF_FFFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Addr          (Addr),
        .InstrCode     (InstrCode),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .halted        (halted),
        .err           (err)
    );

    always #5 clk = ~clk;

    // 36-byte instruction memory; reads beyond it return zero.
    always_comb begin
        InstrCode = 32'h0;
        if (Addr < 32'd36)
            InstrCode = imem[Addr[5:2]];
    end

    // Handshake monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (reset && valid_out && ready_in) begin
            logic [63:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL handshake_extra: got pc=%h instr=%h, expected no transfer", pc_out, instr_out);
            end else begin
                e = exp_q.pop_front();
                if ({pc_out, instr_out} !== e) begin
                    errors++;
                    $display("FAIL handshake: got pc=%h instr=%h, expected pc=%h instr=%h",
                             pc_out, instr_out, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        jump = 1'b0;
        branch_taken = 1'b0;
        jump_target = 32'h0;
        branch_target = 32'h0;
        repeat (2) step();
        exp_q.delete();
    endtask

    task automatic load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                        input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5);
        for (int i = 0; i < 16; i++) imem[i] = 32'h100 + i;
        imem[0] = w0; imem[1] = w1; imem[2] = w2;
        imem[3] = w3; imem[4] = w4; imem[5] = w5;
    endtask

    task automatic test_reset;
        ready_in = 1'b1;
        load(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66);
        do_reset();
        repeat (3) step();
        checks++;
        if ({valid_out, pc_out, instr_out, halted, err, Addr} !== {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: valid=%b pc_out=%h instr=%h halted=%b err=%b Addr=%h, expected all zero",
                     valid_out, pc_out, instr_out, halted, err, Addr);
        end
    endtask

    task automatic test_seq_halt;
        load(32'h11, 32'h22, 32'h33, 32'hFFFF_FFFF, 32'h55, 32'h66);
        do_reset();
        ready_in = 1'b1;
        exp_q.push_back({32'd0, 32'h11});
        exp_q.push_back({32'd4, 32'h22});
        exp_q.push_back({32'd8, 32'h33});
        exp_q.push_back({32'd12, 32'hFFFF_FFFF});
        reset = 1'b1;
        step();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL seq_boot: valid_out=%b, expected 0", valid_out);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({valid_out, pc_out} !== {1'b1, 32'(4 * i)}) begin
                errors++;
                $display("FAIL seq_pc: valid=%b pc_out=%h, expected 1 %h", valid_out, pc_out, 32'(4 * i));
            end
        end
        checks++;
        if ({halted, err} !== 2'b10) begin
            errors++;
            $display("FAIL halt_code_flags: halted=%b err=%b, expected 1 0", halted, err);
        end
        step();
        checks++;
        if ({valid_out, halted, err, Addr} !== {3'b010, 32'd12}) begin
            errors++;
            $display("FAIL halt_code_after: valid=%b halted=%b err=%b Addr=%h, expected 0 1 0 0000000c",
                     valid_out, halted, err, Addr);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL seq_pending: %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        load(32'h11, 32'h22, 32'h33, 32'h44, 32'hFFFF_FFFF, 32'h66);
        do_reset();
        ready_in = 1'b1;
        exp_q.push_back({32'd0, 32'h11});
        exp_q.push_back({32'd4, 32'h22});
        exp_q.push_back({32'd8, 32'h33});
        exp_q.push_back({32'd12, 32'h44});
        exp_q.push_back({32'd16, 32'hFFFF_FFFF});
        reset = 1'b1;
        repeat (3) step();
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({valid_out, pc_out, instr_out, Addr} !== {1'b1, 32'd4, 32'h22, 32'd8}) begin
                errors++;
                $display("FAIL bp_hold: valid=%b pc_out=%h instr=%h Addr=%h, expected 1 4 22 8",
                         valid_out, pc_out, instr_out, Addr);
            end
        end
        ready_in = 1'b1;
        step();
        checks++;
        if ({valid_out, pc_out} !== {1'b1, 32'd8}) begin
            errors++;
            $display("FAIL bp_release: valid=%b pc_out=%h, expected 1 8", valid_out, pc_out);
        end
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_pending: %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_redirect;
        load(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'hFFFF_FFFF);
        do_reset();
        ready_in = 1'b1;
        exp_q.push_back({32'd0, 32'h11});
        exp_q.push_back({32'h10, 32'h55});
        exp_q.push_back({32'h14, 32'hFFFF_FFFF});
        reset = 1'b1;
        repeat (2) step();
        jump = 1'b1; jump_target = 32'h10;
        branch_taken = 1'b1; branch_target = 32'h08;
        #1;
        checks++;
        if (Addr !== 32'd4) begin
            errors++;
            $display("FAIL redir_addr_comb: Addr=%h, expected 00000004", Addr);
        end
        step();
        jump = 1'b0; branch_taken = 1'b0;
        checks++;
        if ({valid_out, Addr} !== {1'b0, 32'h10}) begin
            errors++;
            $display("FAIL redir_bubble: valid=%b Addr=%h, expected 0 00000010", valid_out, Addr);
        end
        step();
        checks++;
        if ({valid_out, pc_out} !== {1'b1, 32'h10}) begin
            errors++;
            $display("FAIL redir_target: valid=%b pc_out=%h, expected 1 00000010", valid_out, pc_out);
        end
        step();
        jump = 1'b1; jump_target = 32'h0;
        step();
        jump = 1'b0;
        checks++;
        if ({valid_out, halted, Addr} !== {2'b01, 32'h14}) begin
            errors++;
            $display("FAIL halt_ignores_jump: valid=%b halted=%b Addr=%h, expected 0 1 00000014",
                     valid_out, halted, Addr);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL redir_pending: %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_misalign;
        int seen;
        load(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66);
        do_reset();
        ready_in = 1'b1;
        exp_q.push_back({32'd0, 32'h11});
        reset = 1'b1;
        repeat (2) step();
        branch_taken = 1'b1; branch_target = 32'h06;
        step();
        branch_taken = 1'b0;
        checks++;
        if ({halted, err, valid_out, Addr} !== {3'b110, 32'd4}) begin
            errors++;
            $display("FAIL misalign_halt: halted=%b err=%b valid=%b Addr=%h, expected 1 1 0 00000004",
                     halted, err, valid_out, Addr);
        end
        seen = 0;
        repeat (3) begin
            step();
            if (valid_out) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL misalign_quiet: valid_out seen %0d times, expected 0", seen);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL misalign_pending: %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_range;
        int n;
        load(32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105);
        do_reset();
        ready_in = 1'b1;
        for (int i = 0; i < 9; i++) exp_q.push_back({32'(4 * i), 32'h100 + 32'(i)});
        reset = 1'b1;
        step();
        n = 0;
        while (!halted && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL range_cycles: halted after %0d cycles, expected 10", n);
        end
        checks++;
        if ({halted, err, valid_out, pc_out, instr_out, Addr} !== {3'b110, 32'd32, 32'h108, 32'd36}) begin
            errors++;
            $display("FAIL range_halt: halted=%b err=%b valid=%b pc_out=%h instr=%h Addr=%h, expected 1 1 0 20 108 24",
                     halted, err, valid_out, pc_out, instr_out, Addr);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL range_pending: %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midrun;
        load(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66);
        do_reset();
        ready_in = 1'b1;
        exp_q.push_back({32'd0, 32'h11});
        exp_q.push_back({32'd4, 32'h22});
        reset = 1'b1;
        repeat (4) step();
        ready_in = 1'b0;
        step();
        checks++;
        if ({valid_out, pc_out, instr_out} !== {1'b1, 32'd8, 32'h33}) begin
            errors++;
            $display("FAIL midrun_hold: valid=%b pc_out=%h instr=%h, expected 1 8 33", valid_out, pc_out, instr_out);
        end
        reset = 1'b0;
        step();
        checks++;
        if ({valid_out, pc_out, instr_out, halted, err, Addr} !== {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL midrun_reset: valid=%b pc_out=%h instr=%h halted=%b err=%b Addr=%h, expected all zero",
                     valid_out, pc_out, instr_out, halted, err, Addr);
        end
        exp_q.push_back({32'd0, 32'h11});
        reset = 1'b1;
        ready_in = 1'b1;
        repeat (2) step();
        checks++;
        if ({valid_out, pc_out, instr_out} !== {1'b1, 32'd0, 32'h11}) begin
            errors++;
            $display("FAIL midrun_restart: valid=%b pc_out=%h instr=%h, expected 1 0 11", valid_out, pc_out, instr_out);
        end
        step();
        ready_in = 1'b0;
        checks++;
        if (pc_out !== 32'd4) begin
            errors++;
            $display("FAIL midrun_second: pc_out=%h, expected 00000004", pc_out);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midrun_pending: %0d pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        jump = 1'b0;
        branch_taken = 1'b0;
        jump_target = 32'h0;
        branch_target = 32'h0;
        ready_in = 1'b0;
        test_reset();
        test_seq_halt();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_range();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
